// File: rtl/replay_iter_sequencer_if.sv
// Handshake/status bundle between the task controller and the
// replay iteration sequencer.
//  master: drives start/abort/counts and PE/bank/stream status
//  slave : drives stream_begin, dispatch_en, indices, busy,
//          task_complete and timeout_err
interface replay_iter_sequencer_if #(
    parameter int NUM_PE     = 4,
    parameter int MAX_REPLAY = 4,
    parameter int MAX_LAYER  = 2
);
    localparam int RW  = $clog2(MAX_REPLAY);
    localparam int LW  = $clog2(MAX_LAYER);
    localparam int CRW = RW + 1;
    localparam int CLW = LW + 1;

    logic              start;
    logic              abort;
    logic [CRW-1:0]    num_replay;
    logic [CLW-1:0]    num_layer;
    logic [NUM_PE-1:0] pe_idle;
    logic [NUM_PE-1:0] bank_busy;
    logic              stream_end;
    logic              vertex_done;

    logic              stream_begin;
    logic              dispatch_en;
    logic [RW-1:0]     replay_iter;
    logic [LW-1:0]     layer_iter;
    logic              busy;
    logic              task_complete;
    logic              timeout_err;

    modport master (
        output start, abort,
        output num_replay, num_layer,
        output pe_idle, bank_busy,
        output stream_end, vertex_done,
        input  stream_begin, dispatch_en,
        input  replay_iter, layer_iter,
        input  busy, task_complete,
        input  timeout_err
    );

    modport slave (
        input  start, abort,
        input  num_replay, num_layer,
        input  pe_idle, bank_busy,
        input  stream_end, vertex_done,
        output stream_begin, dispatch_en,
        output replay_iter, layer_iter,
        output busy, task_complete,
        output timeout_err
    );
endinterface

// File: rtl/replay_iter_sequencer.sv
// Replay/layer iteration sequencer: walks BEGIN/STREAM/DRAIN/VERTEX/
// ADVANCE per iteration with a watchdog, abort and sticky timeout.
// Ports: clk, reset (async, active-low), bus (slave modport).
module replay_iter_sequencer #(
    parameter int NUM_PE     = 4,
    parameter int MAX_REPLAY = 4,
    parameter int MAX_LAYER  = 2,
    parameter int WDOG_W     = 12
) (
    input logic                    clk,
    input logic                    reset,
    replay_iter_sequencer_if.slave bus
);
    localparam int RW  = $clog2(MAX_REPLAY);
    localparam int LW  = $clog2(MAX_LAYER);
    localparam int CRW = RW + 1;
    localparam int CLW = LW + 1;

    typedef enum logic [2:0] {
        IDLE,
        BEGIN,
        STREAM,
        DRAIN,
        VERTEX,
        ADVANCE,
        DONE
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [WDOG_W-1:0] wdog;
    logic [CRW-1:0]    cnt_replay;
    logic [CLW-1:0]    cnt_layer;
    logic [RW-1:0]     replay_q;
    logic [LW-1:0]     layer_q;
    logic              begin_q;
    logic              dispatch_q;
    logic              busy_q;
    logic              done_q;
    logic              tmo_q;

    logic is_busy;
    logic can_start;
    logic counting;
    logic wdog_hit;
    logic drain_ok;
    logic replay_more;
    logic layer_more;

    function automatic logic [CRW-1:0] clamp_r(
        input logic [CRW-1:0] n
    );
        if (n == '0)
            return CRW'(1);
        if (n > CRW'(MAX_REPLAY))
            return CRW'(MAX_REPLAY);
        return n;
    endfunction

    function automatic logic [CLW-1:0] clamp_l(
        input logic [CLW-1:0] n
    );
        if (n == '0)
            return CLW'(1);
        if (n > CLW'(MAX_LAYER))
            return CLW'(MAX_LAYER);
        return n;
    endfunction

    always_comb begin
        is_busy   = (state != IDLE) && (state != DONE);
        can_start = !is_busy && bus.start && !bus.abort;
        counting  = (state == STREAM) || (state == DRAIN) ||
                    (state == VERTEX);
        wdog_hit  = counting && (wdog == '1);
        drain_ok  = (bus.pe_idle == {NUM_PE{1'b1}}) &&
                    (bus.bank_busy == '0);
        replay_more = CRW'(replay_q) < (cnt_replay - CRW'(1));
        layer_more  = CLW'(layer_q) < (cnt_layer - CLW'(1));
    end

    // Priority: abort, then watchdog, then normal progress.
    always_comb begin
        state_n = state;
        if (bus.abort) begin
            if (is_busy)
                state_n = IDLE;
        end else if (wdog_hit) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start)
                        state_n = BEGIN;
                end
                BEGIN: state_n = STREAM;
                STREAM: begin
                    if (bus.stream_end)
                        state_n = DRAIN;
                end
                DRAIN: begin
                    if (drain_ok)
                        state_n = VERTEX;
                end
                VERTEX: begin
                    if (bus.vertex_done)
                        state_n = ADVANCE;
                end
                ADVANCE: begin
                    if (replay_more || layer_more)
                        state_n = BEGIN;
                    else
                        state_n = DONE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    // Outputs are registered from the next state so they line up
    // with the state register with no extra cycle of latency.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            wdog       <= '0;
            cnt_replay <= '0;
            cnt_layer  <= '0;
            replay_q   <= '0;
            layer_q    <= '0;
            begin_q    <= 1'b0;
            dispatch_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
        end else begin
            state <= state_n;

            if (state_n != state)
                wdog <= '0;
            else if (counting && (wdog != '1))
                wdog <= wdog + WDOG_W'(1);

            if (can_start)
                tmo_q <= 1'b0;
            else if (wdog_hit && !bus.abort)
                tmo_q <= 1'b1;

            if (can_start) begin
                cnt_replay <= clamp_r(bus.num_replay);
                cnt_layer  <= clamp_l(bus.num_layer);
                replay_q   <= '0;
                layer_q    <= '0;
            end else if ((state == ADVANCE) && !bus.abort) begin
                if (replay_more) begin
                    replay_q <= replay_q + RW'(1);
                end else if (layer_more) begin
                    replay_q <= '0;
                    layer_q  <= layer_q + LW'(1);
                end
            end

            begin_q    <= (state_n == BEGIN);
            dispatch_q <= (state_n == STREAM);
            busy_q     <= (state_n != IDLE) && (state_n != DONE);
            done_q     <= (state_n == DONE);
        end
    end

    assign bus.stream_begin  = begin_q;
    assign bus.dispatch_en   = dispatch_q;
    assign bus.replay_iter   = replay_q;
    assign bus.layer_iter    = layer_q;
    assign bus.busy          = busy_q;
    assign bus.task_complete = done_q;
    assign bus.timeout_err   = tmo_q;
endmodule

// File: tb/tb_replay_iter_sequencer.sv
// Directed bench for replay_iter_sequencer (WDOG_W=4).
// Checks iteration order, drain gating, watchdog, abort, reset.
module tb_replay_iter_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   passed = 0;
    int   total = 0;
    int   nbeg = 0;
    int   nb0;

    always #5 clk = ~clk;

    replay_iter_sequencer_if #(
        .NUM_PE(4), .MAX_REPLAY(4), .MAX_LAYER(2)
    ) bus ();

    replay_iter_sequencer #(
        .NUM_PE(4), .MAX_REPLAY(4),
        .MAX_LAYER(2), .WDOG_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always @(negedge clk)
        if (bus.stream_begin === 1'b1)
            nbeg = nbeg + 1;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h",
                    tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_begin"}, 32'(bus.stream_begin), 0);
        chk({tag, "_disp"}, 32'(bus.dispatch_en), 0);
        chk({tag, "_replay"}, 32'(bus.replay_iter), 0);
        chk({tag, "_layer"}, 32'(bus.layer_iter), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_done"}, 32'(bus.task_complete), 0);
        chk({tag, "_tmo"}, 32'(bus.timeout_err), 0);
    endtask

    task automatic go(input logic [2:0] nr,
                      input logic [1:0] nl);
        bus.num_replay = nr;
        bus.num_layer  = nl;
        bus.start      = 1'b1;
        step();
        bus.start      = 1'b0;
    endtask

    // Entered in BEGIN; leaves in BEGIN of the next
    // iteration or in DONE when last is set.
    task automatic iter(input int r, input int l,
                        input bit last);
        chk("begin_pulse", 32'(bus.stream_begin), 1);
        chk("replay_idx", 32'(bus.replay_iter), r);
        chk("layer_idx", 32'(bus.layer_iter), l);
        step();
        chk("dispatch_stream", 32'(bus.dispatch_en), 1);
        chk("begin_low", 32'(bus.stream_begin), 0);
        bus.stream_end = 1'b1;
        step();
        bus.stream_end = 1'b0;
        chk("dispatch_drain", 32'(bus.dispatch_en), 0);
        step();
        bus.vertex_done = 1'b1;
        step();
        bus.vertex_done = 1'b0;
        chk("busy_adv", 32'(bus.busy), 1);
        step();
        if (last) begin
            chk("done_flag", 32'(bus.task_complete), 1);
            chk("done_busy", 32'(bus.busy), 0);
        end
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.num_replay  = '0;
        bus.num_layer   = '0;
        bus.pe_idle     = 4'hF;
        bus.bank_busy   = 4'h0;
        bus.stream_end  = 1'b0;
        bus.vertex_done = 1'b0;
        #1;
        chk_zero("rst");
        step();
        step();
        reset = 1'b1;
        step();
        chk("idle_busy", 32'(bus.busy), 0);

        // Basic task: 2 replays, 1 layer
        nb0 = nbeg;
        go(3'd2, 2'd1);
        iter(0, 0, 0);
        iter(1, 0, 1);
        chk("basic_pulses", 32'(nbeg - nb0), 2);
        chk("basic_hold", 32'(bus.replay_iter), 1);

        // Layer wrap: 2 replays, 2 layers
        nb0 = nbeg;
        go(3'd2, 2'd2);
        iter(0, 0, 0);
        iter(1, 0, 0);
        iter(0, 1, 0);
        iter(1, 1, 1);
        chk("wrap_pulses", 32'(nbeg - nb0), 4);
        chk("wrap_layer", 32'(bus.layer_iter), 1);

        // Drain gating; vertex_done held high so any early
        // exit from DRAIN shows as an early DONE.
        go(3'd1, 2'd1);
        step();
        bus.stream_end  = 1'b1;
        bus.pe_idle     = 4'b1110;
        bus.vertex_done = 1'b1;
        step();
        bus.stream_end = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("drain_pe", 32'(bus.task_complete), 0);
        end
        bus.pe_idle   = 4'b1111;
        bus.bank_busy = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("drain_bank", 32'(bus.task_complete), 0);
        end
        bus.bank_busy = 4'b0000;
        step();
        chk("drain_vtx", 32'(bus.task_complete), 0);
        step();
        chk("drain_adv", 32'(bus.task_complete), 0);
        step();
        chk("drain_done", 32'(bus.task_complete), 1);
        bus.vertex_done = 1'b0;

        // Watchdog: stream_end never comes
        go(3'd1, 2'd1);
        step();
        for (int i = 0; i < 14; i++)
            step();
        chk("wd_early", 32'(bus.timeout_err), 0);
        chk("wd_early_busy", 32'(bus.busy), 1);
        step();
        step();
        chk("wd_err", 32'(bus.timeout_err), 1);
        chk("wd_idle", 32'(bus.busy), 0);
        chk("wd_nodone", 32'(bus.task_complete), 0);
        chk("wd_nodisp", 32'(bus.dispatch_en), 0);
        step();
        chk("wd_sticky", 32'(bus.timeout_err), 1);
        go(3'd1, 2'd1);
        chk("wd_clear", 32'(bus.timeout_err), 0);
        chk("wd_restart", 32'(bus.stream_begin), 1);

        // Abort and start together in STREAM
        step();
        chk("ab_stream", 32'(bus.dispatch_en), 1);
        nb0 = nbeg;
        bus.abort = 1'b1;
        bus.start = 1'b1;
        step();
        bus.abort = 1'b0;
        bus.start = 1'b0;
        chk("ab_busy", 32'(bus.busy), 0);
        chk("ab_disp", 32'(bus.dispatch_en), 0);
        chk("ab_done", 32'(bus.task_complete), 0);
        chk("ab_begin", 32'(bus.stream_begin), 0);
        step();
        chk("ab_nopulse", 32'(nbeg - nb0), 0);

        // Clamping: 0 -> 1, 7 -> MAX_REPLAY
        nb0 = nbeg;
        go(3'd0, 2'd0);
        iter(0, 0, 1);
        chk("clamp0_pulses", 32'(nbeg - nb0), 1);
        nb0 = nbeg;
        go(3'd7, 2'd1);
        iter(0, 0, 0);
        iter(1, 0, 0);
        iter(2, 0, 0);
        iter(3, 0, 1);
        chk("clamp7_pulses", 32'(nbeg - nb0), 4);
        chk("clamp7_hold", 32'(bus.replay_iter), 3);

        // Reset mid-VERTEX with non-zero indices
        go(3'd2, 2'd2);
        iter(0, 0, 0);
        step();
        bus.stream_end = 1'b1;
        step();
        bus.stream_end = 1'b0;
        step();
        chk("pre_rst_idx", 32'(bus.replay_iter), 1);
        chk("pre_rst_busy", 32'(bus.busy), 1);
        #2;
        reset = 1'b0;
        #1;
        chk_zero("async_rst");
        step();
        reset = 1'b1;
        step();
        chk("post_rst", 32'(bus.busy), 0);
        bus.stream_end  = 1'b1;
        bus.vertex_done = 1'b1;
        step();
        bus.stream_end  = 1'b0;
        bus.vertex_done = 1'b0;
        chk("stray_busy", 32'(bus.busy), 0);
        chk("stray_begin", 32'(bus.stream_begin), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
